// File: rtl/shift_serdes_pkg.sv
// Shared state encodings and sizing helper for the shift_serdes serialiser/deserialiser.
// Optional parity support is selected with the SHIFT_SERDES_PARITY_EN macro.
package shift_serdes_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_PAR   = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_PAR   = 2'd2
  } rx_state_e;

  // Bit counter must be able to represent 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_serdes_rx.sv
// Receive half of shift_serdes: frame-start qualified serial-to-parallel assembler.
// SHIFT_SERDES_PARITY_EN adds an even-parity bit after the data bits and the RX_PERR output.
module shift_serdes_rx
  import shift_serdes_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             SI,
  input  logic             RX_START,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID
`ifdef SHIFT_SERDES_PARITY_EN
  ,
  output logic             RX_PERR
`endif
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] shifted;
`ifdef SHIFT_SERDES_PARITY_EN
  logic             perr_q, perr_d;
`endif

  // The first bit of a frame walks to the far end of the register after WIDTH shifts.
  assign shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], SI} : {SI, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
`ifdef SHIFT_SERDES_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      RX_IDLE: begin
        if (CE && RX_START) begin
          sr_d    = shifted;
          cnt_d   = CW'(1);
          state_d = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (CE) begin
          sr_d  = shifted;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
`ifdef SHIFT_SERDES_PARITY_EN
            state_d = RX_PAR;
`else
            data_d  = shifted;
            valid_d = 1'b1;
            state_d = RX_IDLE;
`endif
          end
        end
      end
`ifdef SHIFT_SERDES_PARITY_EN
      RX_PAR: begin
        if (CE) begin
          data_d  = sr_q;
          perr_d  = SI ^ (^sr_q);
          valid_d = 1'b1;
          state_d = RX_IDLE;
        end
      end
`endif
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= RX_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef SHIFT_SERDES_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef SHIFT_SERDES_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign RX_DATA  = data_q;
  assign RX_VALID = valid_q;
`ifdef SHIFT_SERDES_PARITY_EN
  assign RX_PERR  = perr_q;
`endif

endmodule

// File: rtl/shift_serdes.sv
// Parametrised shift-register serdes: TX path here, RX path in shift_serdes_rx.
// SHIFT_SERDES_PARITY_EN appends/checks an even-parity bit and exposes RX_PERR.
module shift_serdes
  import shift_serdes_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_VALID,
  output logic             TX_READY,
  output logic             TX_BUSY,
  output logic             SO,
  input  logic             SI,
  input  logic             RX_START,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID
`ifdef SHIFT_SERDES_PARITY_EN
  ,
  output logic             RX_PERR
`endif
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  tx_state_e        tx_state_q, tx_state_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
`ifdef SHIFT_SERDES_PARITY_EN
  logic             tx_par_q, tx_par_d;
`endif

  // Accept does not wait for CE; only shifting is gated by the bit strobe.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sr_d    = tx_sr_q;
    tx_cnt_d   = tx_cnt_q;
`ifdef SHIFT_SERDES_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        if (TX_VALID) begin
          tx_state_d = TX_SHIFT;
          tx_sr_d    = TX_DATA;
          tx_cnt_d   = '0;
`ifdef SHIFT_SERDES_PARITY_EN
          tx_par_d   = ^TX_DATA;
`endif
        end
      end
      TX_SHIFT: begin
        if (CE) begin
          tx_sr_d  = MSB_FIRST ? {tx_sr_q[WIDTH-2:0], 1'b0} : {1'b0, tx_sr_q[WIDTH-1:1]};
          tx_cnt_d = tx_cnt_q + CW'(1);
          if (tx_cnt_q == LAST) begin
`ifdef SHIFT_SERDES_PARITY_EN
            tx_state_d = TX_PAR;
`else
            tx_state_d = TX_IDLE;
`endif
          end
        end
      end
`ifdef SHIFT_SERDES_PARITY_EN
      TX_PAR: begin
        if (CE) tx_state_d = TX_IDLE;
      end
`endif
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    SO = 1'b0;
    case (tx_state_q)
      TX_SHIFT: SO = MSB_FIRST ? tx_sr_q[WIDTH-1] : tx_sr_q[0];
`ifdef SHIFT_SERDES_PARITY_EN
      TX_PAR:   SO = tx_par_q;
`endif
      default:  SO = 1'b0;
    endcase
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      tx_state_q <= TX_IDLE;
      tx_sr_q    <= '0;
      tx_cnt_q   <= '0;
`ifdef SHIFT_SERDES_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_sr_q    <= tx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
`ifdef SHIFT_SERDES_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign TX_READY = (tx_state_q == TX_IDLE);
  assign TX_BUSY  = !TX_READY;

  shift_serdes_rx #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_rx (
    .C       (C),
    .CLR     (CLR),
    .CE      (CE),
    .SI      (SI),
    .RX_START(RX_START),
    .RX_DATA (RX_DATA),
    .RX_VALID(RX_VALID)
`ifdef SHIFT_SERDES_PARITY_EN
    ,
    .RX_PERR (RX_PERR)
`endif
  );

endmodule

// File: tb/tb_shift_serdes.sv
// Directed bench for shift_serdes: an MSB-first and an LSB-first instance, each looped SO->SI.
// Parity scenarios are built when SHIFT_SERDES_PARITY_EN is defined.
module tb_shift_serdes;

`ifdef SHIFT_SERDES_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic       C, CLR, CE, TX_VALID, RX_START;
  logic [7:0] TX_DATA;
  logic       loop_en, si_drv, si;
  logic       TX_READY, TX_BUSY, SO, RX_VALID;
  logic [7:0] RX_DATA;
  logic       tx_ready_l, tx_busy_l, so_l, rx_valid_l;
  logic [7:0] rx_data_l;
`ifdef SHIFT_SERDES_PARITY_EN
  logic       RX_PERR, rx_perr_l;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] rxq[$];

  assign si = loop_en ? SO : si_drv;

  shift_serdes #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .C(C), .CLR(CLR), .CE(CE), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .TX_BUSY(TX_BUSY), .SO(SO), .SI(si),
    .RX_START(RX_START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID)
`ifdef SHIFT_SERDES_PARITY_EN
    , .RX_PERR(RX_PERR)
`endif
  );

  shift_serdes #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .C(C), .CLR(CLR), .CE(CE), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(tx_ready_l), .TX_BUSY(tx_busy_l), .SO(so_l), .SI(so_l),
    .RX_START(RX_START), .RX_DATA(rx_data_l), .RX_VALID(rx_valid_l)
`ifdef SHIFT_SERDES_PARITY_EN
    , .RX_PERR(rx_perr_l)
`endif
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  always @(negedge C) if (RX_VALID) rxq.push_back(RX_DATA);

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    total++; if (SO !== 1'b0) begin bad++; $display("FAIL rst_so: got %b want 0", SO); end
    total++; if (TX_READY !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", TX_READY); end
    total++; if (TX_BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", TX_BUSY); end
    total++; if (RX_DATA !== 8'h00) begin bad++; $display("FAIL rst_rxdata: got %h want 00", RX_DATA); end
    total++; if (RX_VALID !== 1'b0) begin bad++; $display("FAIL rst_rxvalid: got %b want 0", RX_VALID); end
`ifdef SHIFT_SERDES_PARITY_EN
    total++; if (RX_PERR !== 1'b0) begin bad++; $display("FAIL rst_perr: got %b want 0", RX_PERR); end
`endif
    CLR = 1'b0;
    rxq.delete();
    tick();
    TX_DATA = 8'hA5; TX_VALID = 1'b1; CE = 1'b1;
    tick();
    TX_VALID = 1'b0; RX_START = 1'b1;
    tick();
    RX_START = 1'b0;
    repeat (3) tick();
    total++; if (TX_BUSY !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", TX_BUSY); end
    #2 CLR = 1'b1;
    #1;
    total++; if (SO !== 1'b0) begin bad++; $display("FAIL clr_so: got %b want 0", SO); end
    total++; if (TX_READY !== 1'b1) begin bad++; $display("FAIL clr_ready: got %b want 1", TX_READY); end
    tick();
    CLR = 1'b0;
    repeat (12) tick();
    total++; if (rxq.size() != 0) begin bad++; $display("FAIL clr_no_valid: got %0d pulses want 0", rxq.size()); end
    total++; if (RX_DATA !== 8'h00) begin bad++; $display("FAIL clr_rxdata: got %h want 00", RX_DATA); end
  endtask

  task automatic test_loopback_msb;
    logic [7:0] w;
    w = 8'hA5;
    rxq.delete(); loop_en = 1'b1; CE = 1'b1;
    TX_DATA = w; TX_VALID = 1'b1;
    tick();
    TX_VALID = 1'b0; RX_START = 1'b1;
    for (int i = 0; i < NBITS; i++) begin
      if (i < 8) begin
        total++;
        if (SO !== w[7-i]) begin bad++; $display("FAIL msb_so_bit%0d: got %b want %b", i, SO, w[7-i]); end
      end
      tick();
      RX_START = 1'b0;
    end
    total++; if (RX_VALID !== 1'b1) begin bad++; $display("FAIL msb_rxvalid: got %b want 1", RX_VALID); end
    total++; if (RX_DATA !== 8'hA5) begin bad++; $display("FAIL msb_rxdata: got %h want a5", RX_DATA); end
    total++; if (TX_READY !== 1'b1) begin bad++; $display("FAIL msb_ready: got %b want 1", TX_READY); end
    tick();
    total++; if (RX_VALID !== 1'b0) begin bad++; $display("FAIL msb_valid_pulse: got %b want 0", RX_VALID); end
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL msb_pulses: got %0d want 1", rxq.size()); end
  endtask

  task automatic test_lsb_first;
    logic [7:0] w;
    w = 8'h01;
    CE = 1'b1;
    TX_DATA = w; TX_VALID = 1'b1;
    tick();
    TX_VALID = 1'b0; RX_START = 1'b1;
    for (int i = 0; i < NBITS; i++) begin
      if (i < 8) begin
        total++;
        if (so_l !== w[i]) begin bad++; $display("FAIL lsb_so_bit%0d: got %b want %b", i, so_l, w[i]); end
      end
      tick();
      RX_START = 1'b0;
    end
    total++; if (rx_valid_l !== 1'b1) begin bad++; $display("FAIL lsb_rxvalid: got %b want 1", rx_valid_l); end
    total++; if (rx_data_l !== 8'h01) begin bad++; $display("FAIL lsb_rxdata: got %h want 01", rx_data_l); end
    tick();
  endtask

  task automatic test_ce_throttle;
    logic [7:0] w;
    w = 8'h3C;
    rxq.delete(); loop_en = 1'b1; CE = 1'b0;
    TX_DATA = w; TX_VALID = 1'b1;
    tick();
    TX_VALID = 1'b0;
    for (int b = 0; b < NBITS; b++) begin
      for (int k = 0; k < 3; k++) begin
        CE = (k == 2);
        RX_START = (b == 0 && k == 2);
        if (b == 3 && k == 0) begin TX_DATA = 8'hFF; TX_VALID = 1'b1; end
        if (b == 3 && k == 2) begin TX_DATA = w; TX_VALID = 1'b0; end
        if (b < 8) begin
          total++;
          if (SO !== w[7-b]) begin bad++; $display("FAIL ce_so_bit%0d_clk%0d: got %b want %b", b, k, SO, w[7-b]); end
        end
        tick();
      end
    end
    CE = 1'b0; RX_START = 1'b0;
    total++; if (RX_VALID !== 1'b1) begin bad++; $display("FAIL ce_rxvalid: got %b want 1", RX_VALID); end
    total++; if (RX_DATA !== 8'h3C) begin bad++; $display("FAIL ce_rxdata: got %h want 3c", RX_DATA); end
    total++; if (TX_READY !== 1'b1) begin bad++; $display("FAIL ce_ready: got %b want 1", TX_READY); end
    tick();
    total++; if (RX_VALID !== 1'b0) begin bad++; $display("FAIL ce_valid_pulse: got %b want 0", RX_VALID); end
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL ce_pulses: got %0d want 1", rxq.size()); end
  endtask

  task automatic test_back_to_back;
    int acc, just_acc, idle;
    logic start_pend;
    acc = 0; just_acc = 0; idle = 0; start_pend = 1'b0;
    rxq.delete(); loop_en = 1'b1; CE = 1'b1;
    TX_DATA = 8'h12; TX_VALID = 1'b1;
    for (int i = 0; i < 40; i++) begin
      RX_START = start_pend;
      start_pend = 1'b0;
      if (just_acc == 1) TX_DATA = 8'h34;
      if (just_acc == 2) TX_VALID = 1'b0;
      just_acc = 0;
      if (acc == 1 && TX_READY) idle++;
      if (TX_READY && TX_VALID) begin
        acc++;
        just_acc = acc;
        start_pend = 1'b1;
      end
      tick();
    end
    RX_START = 1'b0;
    total++; if (acc != 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2", acc); end
    total++; if (idle != 1) begin bad++; $display("FAIL b2b_gap: got %0d want 1", idle); end
    total++; if (rxq.size() != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", rxq.size()); end
    if (rxq.size() >= 2) begin
      total++; if (rxq[0] !== 8'h12) begin bad++; $display("FAIL b2b_word0: got %h want 12", rxq[0]); end
      total++; if (rxq[1] !== 8'h34) begin bad++; $display("FAIL b2b_word1: got %h want 34", rxq[1]); end
    end
  endtask

`ifdef SHIFT_SERDES_PARITY_EN
  task automatic test_parity;
    logic [7:0] w;
    w = 8'h07;
    for (int pass = 0; pass < 2; pass++) begin
      loop_en = 1'b1; CE = 1'b1; si_drv = 1'b0;
      TX_DATA = w; TX_VALID = 1'b1;
      tick();
      TX_VALID = 1'b0; RX_START = 1'b1;
      for (int i = 0; i < 9; i++) begin
        if (i == 8) begin
          total++;
          if (SO !== 1'b1) begin bad++; $display("FAIL par_so_bit8: got %b want 1", SO); end
          if (pass == 1) loop_en = 1'b0;
        end
        tick();
        RX_START = 1'b0;
      end
      loop_en = 1'b1;
      total++; if (RX_VALID !== 1'b1) begin bad++; $display("FAIL par_rxvalid%0d: got %b want 1", pass, RX_VALID); end
      total++; if (RX_DATA !== 8'h07) begin bad++; $display("FAIL par_rxdata%0d: got %h want 07", pass, RX_DATA); end
      total++;
      if (RX_PERR !== (pass == 1)) begin
        bad++; $display("FAIL par_perr%0d: got %b want %0d", pass, RX_PERR, pass);
      end
      tick();
    end
  endtask
`endif

  initial begin
    CLR = 1'b1; CE = 1'b0; TX_VALID = 1'b0; TX_DATA = 8'h00;
    RX_START = 1'b0; loop_en = 1'b1; si_drv = 1'b0;
    test_reset();
    tick();
    test_loopback_msb();
    tick();
    test_lsb_first();
    tick();
    test_ce_throttle();
    tick();
    test_back_to_back();
`ifdef SHIFT_SERDES_PARITY_EN
    tick();
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
